code_sequencer: RTL
===================

Name: code_sequencer

Overview:
- Step sequencer that plays a programmable pattern of 4-bit codes (0 = silence, 1..8 = channel select), one code per step, at a programmable step period.
- Sits directly upstream of the registered 4-to-8 code decoder; out_code drives the decoder's in_code.
- Pattern RAM is loaded through a simple write port from the AXI register slave; playback is controlled by start/stop pulses.

Parameters:
- STEPS, 16, pattern depth; must be a power of 2.
- ADDR_W, 4, log2(STEPS); width of the step index.
- CODE_W, 4, width of a code word.
- PER_W, 24, width of the step-period counter.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- wr_en, input, 1, writes wr_code into pattern[wr_addr] on this edge.
- wr_addr, input, ADDR_W, pattern write address.
- wr_code, input, CODE_W, pattern write data.
- start, input, 1, single-cycle pulse that starts or restarts playback from step 0.
- stop, input, 1, single-cycle pulse that aborts playback.
- loop, input, 1, 1 = wrap to step 0 after the last step; 0 = single pass. Sampled at start.
- len, input, ADDR_W, index of the last step played (pattern length is len+1). Sampled at start.
- period, input, PER_W, clk cycles per step; 0 is treated as 1. Sampled at start.
- out_code, output, CODE_W, registered code for the current step; 0 when idle.
- step, output, ADDR_W, current step index.
- busy, output, 1, high while in PLAY.
- done, output, 1, one-cycle pulse when a non-loop pass completes.

Behaviour:
- Reset (async, rst=1): state IDLE, out_code=0, step=0, busy=0, done=0, tick counter=0, all pattern entries=0, latched len/period/loop=0.
- States: IDLE and PLAY. busy is high exactly when the state is PLAY.
- IDLE + start (stop=0) at edge k:
  - latch len, period (0→1) and loop;
  - step=0, tick=0, state=PLAY;
  - out_code=pattern[0]. The value is visible after edge k, so latency from start to the first code is 1 cycle.
- PLAY, per cycle:
  - If tick != period_l-1: tick++.
  - Else tick=0 and step advance:
    - step != len_l: step++, out_code=pattern[step+1].
    - step == len_l and loop_l=1: step=0, out_code=pattern[0].
    - step == len_l and loop_l=0: state=IDLE, out_code=0, step=0, done=1 for exactly this one cycle.
  - Each step therefore holds out_code for exactly period_l cycles.
- stop (any state): next edge → IDLE, out_code=0, step=0, tick=0, no done pulse.
- start and stop on the same edge: stop wins.
- start while in PLAY: restart from step 0 with freshly latched len/period/loop; no done pulse.
- out_code is captured only on step entry. A write to the currently playing step does not change out_code until that step is re-entered. A write to any other step takes effect whenever that step is next entered.
- A write and a read of the same address on the same edge: the read returns the old value.
- Out-of-range codes 9..15 are passed through unchanged; the downstream decoder maps them to 0.
- Changes to len/period/loop during PLAY have no effect until the next start.
- Arithmetic: tick is PER_W bits unsigned. step wraps modulo STEPS, so len=STEPS-1 with loop runs through all entries.

Decomposition:
- Shared package seq_pkg: CODE_W, ADDR_W, PER_W, CODE_SILENT=0, CODE_MAX=8, and the state enum {IDLE, PLAY}.
- One natural sub-module, step_timer: the period counter with load, clear and a tick-terminal output. Pattern RAM and FSM stay in code_sequencer.

Test Plan:
- Reset → write pattern[0..2]={1,5,8}, len=2, period=3, loop=0, start → out_code 1,1,1,5,5,5,8,8,8 starting the cycle after start, then 0; done high for 1 cycle at the 0 transition; busy high for exactly 9 cycles; decoder downstream yields 0x01, 0x10, 0x80, then 0x00.
- Same pattern with loop=1 → sequence 1,5,8 repeats; step goes 0,1,2,0; no done pulse; stop at cycle 20 → out_code=0 and busy=0 on the next cycle.
- period=0, len=3, pattern={2,3,4,9} → one code per cycle: 2,3,4,9, then 0 and done.
- start during PLAY at step 2 → step=0 and out_code=pattern[0] next cycle; start and stop on the same edge → IDLE, out_code=0.
- Write pattern[1]=7 while step 1 is playing with pattern[1]=5 → 5 is held for the full period; with loop=1 the second pass plays 7.
- Assert rst mid-play → out_code, busy and step go to 0 immediately (async); the pattern is cleared, so a new start with len=0 outputs 0.

Source files
------------

// File: rtl/code_sequencer_pkg.sv
// rtl/code_sequencer_pkg.sv - shared widths, code constants and FSM state type for the sequencer
package seq_pkg;
  localparam int STEPS  = 16;
  localparam int ADDR_W = 4;
  localparam int CODE_W = 4;
  localparam int PER_W  = 24;

  localparam logic [CODE_W-1:0] CODE_SILENT = 4'd0;
  localparam logic [CODE_W-1:0] CODE_MAX    = 4'd8;

  typedef enum logic {IDLE, PLAY} seq_state_t;

  // A programmed period of 0 behaves as one cycle per step.
  function automatic logic [PER_W-1:0] norm_period(input logic [PER_W-1:0] p);
    return (p == '0) ? PER_W'(1) : p;
  endfunction
endpackage

// File: rtl/code_sequencer_if.sv
// rtl/code_sequencer_if.sv - pattern write port, playback control and code output bundle
interface code_sequencer_if;
  import seq_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CODE_W-1:0] wr_code;
  logic              start;
  logic              stop;
  logic              loop;
  logic [ADDR_W-1:0] len;
  logic [PER_W-1:0]  period;
  logic [CODE_W-1:0] out_code;
  logic [ADDR_W-1:0] step;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_code, start, stop, loop, len, period,
    input  out_code, step, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_code, start, stop, loop, len, period,
    output out_code, step, busy, done
  );
endinterface

// File: rtl/code_sequencer_step_timer.sv
// rtl/code_sequencer_step_timer.sv - step period counter with load, clear and terminal flag
module step_timer
  import seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [PER_W-1:0] i_period,
  output logic             o_terminal
);
  logic [PER_W-1:0] r_tick;
  logic [PER_W-1:0] r_period_l;
  logic             w_terminal;

  assign w_terminal = (r_tick == r_period_l - PER_W'(1));
  assign o_terminal = w_terminal;

  // Clear dominates load so a simultaneous stop/start leaves the counter idle at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick     <= '0;
      r_period_l <= '0;
    end else if (i_clear) begin
      r_tick <= '0;
    end else if (i_load) begin
      r_tick     <= '0;
      r_period_l <= norm_period(i_period);
    end else if (i_en) begin
      r_tick <= w_terminal ? '0 : r_tick + PER_W'(1);
    end
  end
endmodule

// File: rtl/code_sequencer.sv
// rtl/code_sequencer.sv - plays a programmable pattern of 4-bit codes at a programmable step period
module code_sequencer
  import seq_pkg::*;
(
  input logic                clk,
  input logic                rst,
  code_sequencer_if.slave    bus
);
  logic [CODE_W-1:0] r_pattern [STEPS];
  seq_state_t        r_state;
  logic [CODE_W-1:0] r_code;
  logic [ADDR_W-1:0] r_step;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_len_l;
  logic              r_loop_l;

  logic              w_load;
  logic              w_terminal;
  logic [ADDR_W-1:0] w_next_step;

  assign w_load      = bus.start & ~bus.stop;
  assign w_next_step = r_step + ADDR_W'(1);

  step_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_clear    (bus.stop),
    .i_en       (r_state == PLAY),
    .i_period   (bus.period),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) r_pattern[i] <= CODE_SILENT;
    end else if (bus.wr_en) begin
      r_pattern[bus.wr_addr] <= bus.wr_code;
    end
  end

  // Codes are captured only on step entry, so pattern writes never disturb the step in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_code   <= CODE_SILENT;
      r_step   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_len_l  <= '0;
      r_loop_l <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.stop) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_code  <= CODE_SILENT;
        r_step  <= '0;
      end else if (bus.start) begin
        r_state  <= PLAY;
        r_busy   <= 1'b1;
        r_len_l  <= bus.len;
        r_loop_l <= bus.loop;
        r_step   <= '0;
        r_code   <= r_pattern[0];
      end else begin
        case (r_state)
          IDLE: ;
          PLAY: begin
            if (w_terminal) begin
              if (r_step != r_len_l) begin
                r_step <= w_next_step;
                r_code <= r_pattern[w_next_step];
              end else if (r_loop_l) begin
                r_step <= '0;
                r_code <= r_pattern[0];
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_code  <= CODE_SILENT;
                r_step  <= '0;
                r_done  <= 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.out_code = r_code;
  assign bus.step     = r_step;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule
